// File: rtl/io_sequencer.sv
// io_sequencer: registered command latch with capture handshake on the input side,
// and a DEPTH-entry (cmd, data) FIFO drained over valid/ready on the output side.
module io_sequencer #(
    parameter int IC_N  = 5,
    parameter int OD_N  = 32,
    parameter int OC_N  = 2,
    parameter int DEPTH = 4
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            in_valid,
    input  logic [IC_N-1:0] in_cmd,
    output logic            in_ack,
    output logic            cmd_valid,
    output logic [IC_N-1:0] cmd_Q,
    input  logic            cmd_take,
    input  logic            push_ack,
    input  logic            push_num,
    input  logic [OD_N-1:0] push_data,
    output logic            full,
    output logic            overflow,
    output logic            out_valid,
    output logic [OC_N-1:0] out_cmd,
    output logic [OD_N-1:0] out_data,
    input  logic            out_ready
);

    localparam logic [OC_N-1:0] OC_NON = '0;
    localparam logic [OC_N-1:0] OC_ACK = OC_N'(1);
    localparam logic [OC_N-1:0] OC_NUM = OC_N'(2);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = OC_N + OD_N;

    // ------------------------------------------------------------------
    // Input side: single-entry command latch
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } in_state_t;

    in_state_t       state_q, state_d;
    logic [IC_N-1:0] cmd_q, cmd_d;
    logic            ack_q, ack_d;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        ack_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_HOLD;
                    cmd_d   = in_cmd;
                    ack_d   = 1'b1;
                end
            end
            ST_HOLD: begin
                if (cmd_take) state_d = ST_DRAIN;
            end
            // Wait for the producer to drop in_valid so a held level is captured once.
            ST_DRAIN: begin
                if (!in_valid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ack    = ack_q;
    assign cmd_valid = (state_q == ST_HOLD);
    assign cmd_Q     = cmd_q;

    // ------------------------------------------------------------------
    // Output side: circular FIFO of {cmd, data} records
    // ------------------------------------------------------------------
    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic          pop;
    logic [1:0]    need;
    logic [CW:0]   free_slots;
    logic          accept;
    logic          we0, we1;
    logic [PW-1:0] wr_addr1;
    logic [EW-1:0] wr_data0;
    logic [EW-1:0] ack_entry;
    logic [1:0]    added;
    logic [EW-1:0] head;

    assign ack_entry = {OC_ACK, {OD_N{1'b0}}};

    always_comb begin
        pop        = (count_q != '0) && out_ready;
        need       = {1'b0, push_num} + {1'b0, push_ack};
        // A pop in the same cycle frees its slot for the push decision.
        free_slots = (CW+1)'(DEPTH) - {1'b0, count_q} + (CW+1)'(pop);
        accept     = ((CW+1)'(need) <= free_slots);
        added      = accept ? need : 2'd0;
        we0        = accept && (push_num || push_ack);
        we1        = accept && push_num && push_ack;
        wr_addr1   = wr_ptr_q + PW'(1);
        wr_data0   = push_num ? {OC_NUM, push_data} : ack_entry;
        wr_ptr_d   = wr_ptr_q + PW'(added);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        count_d    = count_q + CW'(added) - CW'(pop);
        overflow_d = overflow_q || ((need != 2'd0) && !accept);
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage carries no reset; empty-state outputs are masked by count below.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            if (we0) mem_q[wr_ptr_q] <= wr_data0;
            if (we1) mem_q[wr_addr1] <= ack_entry;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign out_valid = (count_q != '0);
    assign out_cmd   = out_valid ? head[EW-1:OD_N] : OC_NON;
    assign out_data  = out_valid ? head[OD_N-1:0] : '0;
    assign full      = (count_q >= CW'(DEPTH - 1));
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_io_sequencer.sv
// Randomized and directed bench for io_sequencer; expectations come from a queue-based
// behavioural model of the command latch and the output FIFO.
module tb_io_sequencer;

    localparam int IC_N  = 5;
    localparam int OD_N  = 32;
    localparam int OC_N  = 2;
    localparam int DEPTH = 4;

    logic            Clock;
    logic            Reset;
    logic            in_valid;
    logic [IC_N-1:0] in_cmd;
    logic            in_ack;
    logic            cmd_valid;
    logic [IC_N-1:0] cmd_Q;
    logic            cmd_take;
    logic            push_ack;
    logic            push_num;
    logic [OD_N-1:0] push_data;
    logic            full;
    logic            overflow;
    logic            out_valid;
    logic [OC_N-1:0] out_cmd;
    logic [OD_N-1:0] out_data;
    logic            out_ready;

    io_sequencer #(
        .IC_N(IC_N), .OD_N(OD_N), .OC_N(OC_N), .DEPTH(DEPTH)
    ) dut (
        .Clock(Clock), .Reset(Reset),
        .in_valid(in_valid), .in_cmd(in_cmd), .in_ack(in_ack),
        .cmd_valid(cmd_valid), .cmd_Q(cmd_Q), .cmd_take(cmd_take),
        .push_ack(push_ack), .push_num(push_num), .push_data(push_data),
        .full(full), .overflow(overflow),
        .out_valid(out_valid), .out_cmd(out_cmd), .out_data(out_data),
        .out_ready(out_ready)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Behavioural model: command holder flags plus a record queue.
    bit                   m_holding;
    bit                   m_wait_low;
    bit                   m_ack;
    logic [IC_N-1:0]      m_cmd;
    bit                   m_ovf;
    logic [OC_N+OD_N-1:0] m_q[$];

    task automatic model_update();
        int  free;
        int  need;
        bit  popped;
        if (!Reset) begin
            m_holding  = 0;
            m_wait_low = 0;
            m_ack      = 0;
            m_cmd      = '0;
            m_ovf      = 0;
            m_q.delete();
            return;
        end
        m_ack = 0;
        if (m_holding) begin
            if (cmd_take) begin
                m_holding  = 0;
                m_wait_low = 1;
            end
        end else if (m_wait_low) begin
            if (!in_valid) m_wait_low = 0;
        end else if (in_valid) begin
            m_holding = 1;
            m_cmd     = in_cmd;
            m_ack     = 1;
        end
        popped = (m_q.size() > 0) && out_ready;
        free   = DEPTH - m_q.size() + (popped ? 1 : 0);
        need   = int'(push_num) + int'(push_ack);
        if (popped) void'(m_q.pop_front());
        if (need > free) m_ovf = 1;
        else begin
            if (push_num) m_q.push_back({2'd2, push_data});
            if (push_ack) m_q.push_back({2'd1, 32'd0});
        end
    endtask

    task automatic check_all();
        logic [OC_N+OD_N-1:0] head;
        bit                   v;
        v    = (m_q.size() > 0);
        head = v ? m_q[0] : '0;
        chk("out_valid", 64'(out_valid), 64'(v));
        chk("out_cmd",   64'(out_cmd),   64'(head[OC_N+OD_N-1:OD_N]));
        chk("out_data",  64'(out_data),  64'(head[OD_N-1:0]));
        chk("in_ack",    64'(in_ack),    64'(m_ack));
        chk("cmd_valid", 64'(cmd_valid), 64'(m_holding));
        chk("cmd_Q",     64'(cmd_Q),     64'(m_cmd));
        chk("full",      64'(full),      64'(m_q.size() >= DEPTH - 1));
        chk("overflow",  64'(overflow),  64'(m_ovf));
    endtask

    task automatic step();
        @(posedge Clock);
        model_update();
        @(negedge Clock);
        if (in_ack) ack_cnt++;
        check_all();
    endtask

    task automatic idle_inputs();
        in_valid  = 0;
        in_cmd    = '0;
        cmd_take  = 0;
        push_ack  = 0;
        push_num  = 0;
        push_data = '0;
        out_ready = 0;
    endtask

    task automatic do_reset();
        Reset = 0;
        step();
        Reset = 1;
    endtask

    initial begin
        Reset = 0;
        idle_inputs();
        step();
        step();
        Reset = 1;
        step();
        chk("rst_out_cmd",  64'(out_cmd),  64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_in_ack",   64'(in_ack),   64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));

        // Held in_valid: one capture, one ack.
        ack_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1;
            in_cmd   = 5'h03;
            cmd_take = (i == 3);
            step();
        end
        cmd_take = 0;
        chk("ack_pulses", 64'(ack_cnt), 64'(1));
        chk("held_cmd",   64'(cmd_Q),   64'(5'h03));
        in_valid = 0;
        step();
        in_valid = 1;
        in_cmd   = 5'h0A;
        step();
        chk("recapture_ack", 64'(in_ack), 64'(1));
        chk("recapture_cmd", 64'(cmd_Q),  64'(5'h0A));
        cmd_take = 1;
        in_valid = 0;
        step();
        cmd_take = 0;
        step();

        // NUM and ACK in one cycle.
        do_reset();
        out_ready = 1;
        push_num  = 1;
        push_ack  = 1;
        push_data = 32'd1234;
        step();
        push_num = 0;
        push_ack = 0;
        chk("pair_num_cmd",  64'(out_cmd),  64'(2));
        chk("pair_num_data", 64'(out_data), 64'(1234));
        step();
        chk("pair_ack_cmd",  64'(out_cmd),  64'(1));
        chk("pair_ack_data", 64'(out_data), 64'(0));
        step();
        chk("pair_empty", 64'(out_cmd), 64'(0));

        // Five pushes into four slots.
        do_reset();
        out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            push_num  = 1;
            push_data = 32'(100 + i);
            step();
        end
        push_num = 0;
        chk("ovf_set", 64'(overflow), 64'(1));
        out_ready = 1;
        for (int i = 0; i < 6; i++) step();
        chk("ovf_sticky", 64'(overflow), 64'(1));

        // Push while full with a simultaneous pop.
        do_reset();
        out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            push_num  = 1;
            push_data = 32'(20 + i);
            step();
        end
        out_ready = 1;
        push_data = 32'd7;
        step();
        push_num = 0;
        chk("fullpop_full", 64'(full),     64'(1));
        chk("fullpop_ovf",  64'(overflow), 64'(0));
        for (int i = 0; i < 3; i++) step();
        chk("fullpop_last", 64'(out_data), 64'(7));
        step();

        // Reset while holding a command with queued records.
        do_reset();
        in_valid  = 1;
        in_cmd    = 5'h11;
        out_ready = 0;
        step();
        in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            push_num  = 1;
            push_data = 32'(50 + i);
            step();
        end
        push_num = 0;
        Reset    = 0;
        step();
        chk("midrst_cmd_valid", 64'(cmd_valid), 64'(0));
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        Reset     = 1;
        push_num  = 1;
        push_data = 32'd99;
        step();
        push_num = 0;
        chk("midrst_first", 64'(out_data), 64'(99));

        // Random traffic.
        idle_inputs();
        for (int i = 0; i < 800; i++) begin
            Reset = ($urandom_range(0, 99) != 0);
            if (in_valid) in_valid = ($urandom_range(0, 9) >= 3);
            else          in_valid = ($urandom_range(0, 9) < 3);
            in_cmd    = IC_N'($urandom);
            cmd_take  = ($urandom_range(0, 9) < 4);
            push_num  = ($urandom_range(0, 9) < 4);
            push_ack  = ($urandom_range(0, 9) < 3);
            push_data = $urandom;
            out_ready = ($urandom_range(0, 9) < 6);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_sequencer.md
# io_sequencer

Parametrised, clocked successor to the combinational I/O decode in the calculator controller. Sits between the controller FSM and the external input/output interfaces. The input side is a registered single-entry command latch with a handshake FSM. The output side is a DEPTH-entry FIFO of (cmd, data) records drained over a valid/ready handshake, so the controller can emit results back-to-back without stalling.

## Interface
- `IC_N`, default 5: input command width.
- `OD_N`, default 32: output data width.
- `OC_N`, default 2: output command width; encodings are the `OC_*` definitions (NON, ACK, NUM).
- `DEPTH`, default 4: output FIFO entries, power of two, ≥2.
- `Clock` input, 1: rising-edge clock.
- `Reset` input, 1: synchronous reset, active-low.
- `in_valid` input, 1: external command present (level, held until acked).
- `in_cmd` input, `IC_N`: external command.
- `in_ack` output, 1: one-cycle pulse, command captured.
- `cmd_valid` output, 1: latched command available to controller.
- `cmd_Q` output, `IC_N`: latched command.
- `cmd_take` input, 1: controller consumes `cmd_Q`.
- `push_ack` input, 1: enqueue {`OC_ACK`, 0}.
- `push_num` input, 1: enqueue {`OC_NUM`, `push_data`}.
- `push_data` input, `OD_N`: number to output.
- `full` output, 1: fewer than 2 free entries.
- `overflow` output, 1: sticky, a push was dropped.
- `out_valid` output, 1: FIFO head valid.
- `out_cmd` output, `OC_N`: head command; `OC_NON` when empty.
- `out_data` output, `OD_N`: head data; 0 when empty.
- `out_ready` input, 1: external sink accepts head.

## Operation
- Input FSM states:
  - IDLE: if `in_valid`, capture `in_cmd` into `cmd_Q` and go to HOLD.
  - HOLD: `cmd_valid`=1. On `cmd_take`, go to DRAIN.
  - DRAIN: wait for `in_valid`=0, then go to IDLE. This guarantees one capture per producer assertion, even if `in_valid` stays high.
- `in_ack` is a registered pulse, high the cycle after capture (the first HOLD cycle) only.
- `cmd_Q` holds its value outside HOLD and is not cleared.
- Output FIFO: circular buffer of {`OC_N`+`OD_N`} bits, with read/write pointers and a log2(`DEPTH`)+1-bit count.
- Push rules:
  - `push_num` alone: 1 entry.
  - `push_ack` alone: 1 entry with data 0.
  - Both in the same cycle: 2 entries, NUM first then ACK, atomically.
- Free slots for the push decision = `DEPTH` − count + (pop this cycle ? 1 : 0). A push needing more slots than are free is dropped entirely (never partial), and `overflow` is set.
- `overflow` is cleared only by reset.
- Pop occurs when `out_valid` && `out_ready`.
- `full` = (count ≥ `DEPTH`−1), from the registered count.

## Timing
- Reset (`Reset`=0 at a clock edge) values:
  - FSM=IDLE; `in_ack`=0, `cmd_valid`=0, `cmd_Q`=0.
  - FIFO pointers and count=0; `out_valid`=0, `out_cmd`=`OC_NON`, `out_data`=0.
  - `overflow`=0.
- Reset mid-operation discards any held command and all queued entries. Reset has priority over every other input.
- Input latency: `in_valid` high at edge N (IDLE) → `in_ack`=1 and `cmd_valid`=1 after edge N. `in_ack`=0 after N+1.
- `cmd_take` while not in HOLD is ignored.
- Output latency: push at edge N into an empty FIFO → `out_valid` after edge N. There is no same-cycle bypass.
- `out_cmd`/`out_data` are driven from registered FIFO state, so they are glitch-free. They must stay stable while `out_valid` && !`out_ready`.
- Simultaneous push and pop when count=`DEPTH`: the pop frees a slot, so a single push is accepted and count is unchanged.
- Pointers wrap modulo `DEPTH`.

## Test plan
- Reset, then idle → `out_cmd`=`OC_NON`, `out_data`=0, `in_ack`=0, `overflow`=0.
- Hold `in_valid`=1 with `in_cmd`=5'h03 for 10 cycles and pulse `cmd_take` at cycle 3 → exactly one `in_ack` pulse, `cmd_Q`=5'h03, and no recapture until `in_valid` falls then rises.
- `push_num` with 32'd1234 and `push_ack` in the same cycle, `out_ready`=1 → NUM/1234 then ACK/0 on consecutive cycles, then `OC_NON`.
- `out_ready`=0 with 5 single pushes at `DEPTH`=4 → 4 accepted, 5th dropped, `overflow`=1 and stays 1. Drain order matches push order.
- FIFO at count=4, `push_num` with 32'd7 and a pop in the same cycle → accepted, count stays 4, and 7 emerges last.
- Assert `Reset`=0 in HOLD with 3 entries queued → `cmd_valid`=0, `out_valid`=0 the next cycle, and a subsequent push emerges first.
